card_shoe: RTL and testbench



---
 rtl/card_shoe_pkg.sv | 25 ++
 rtl/card_shoe_if.sv | 16 +
 rtl/lfsr16.sv | 23 ++
 rtl/card_shoe.sv | 93 +++++++++
 tb/tb_card_shoe.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/card_shoe_pkg.sv
// card_shoe_pkg: shared card fields, shoe states and LFSR helpers
package card_shoe_pkg;
  localparam int RANK_W = 4;
  localparam int SUIT_W = 2;
  localparam int CARD_W = RANK_W + SUIT_W;
  localparam int DECK_SIZE = 52;
  localparam logic [RANK_W-1:0] ACE = 4'd1;
  localparam logic [RANK_W-1:0] JACK = 4'd11;
  localparam logic [RANK_W-1:0] QUEEN = 4'd12;
  localparam logic [RANK_W-1:0] KING = 4'd13;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  typedef enum logic [1:0] {S_FILL, S_SHUFFLE, S_READY, S_EMPTY} shoe_state_e;
  typedef logic [CARD_W-1:0] card_t;
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? (s >> 1) ^ LFSR_TAPS : s >> 1;
  endfunction
  function automatic card_t card_of(input int k);
    return {SUIT_W'(k / 13), RANK_W'(k % 13) + ACE};
  endfunction
  function automatic logic [5:0] mask_of(input logic [5:0] i);
    return i <= 6'd1 ? 6'd1 : i <= 6'd3 ? 6'd3 : i <= 6'd7 ? 6'd7 :
           i <= 6'd15 ? 6'd15 : i <= 6'd31 ? 6'd31 : 6'd63;
  endfunction
endpackage

// File: rtl/card_shoe_if.sv
// card_shoe_if: control and deal signals between game logic and the shoe
interface card_shoe_if;
  import card_shoe_pkg::*;
  logic i_shuffle;
  logic i_entropy;
  logic i_draw;
  card_t o_card;
  logic o_cardValid;
  logic o_ready;
  logic [5:0] o_cardsLeft;
  logic o_drawError;
  modport master(output i_shuffle, i_entropy, i_draw,
                 input o_card, o_cardValid, o_ready, o_cardsLeft, o_drawError);
  modport slave(input i_shuffle, i_entropy, i_draw,
                output o_card, o_cardValid, o_ready, o_cardsLeft, o_drawError);
endinterface

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR with optional XOR mix-in and zero-state guard
module lfsr16 import card_shoe_pkg::*; #(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mix,
  input  logic [15:0] i_mix_val,
  output logic [15:0] o_state
);
  logic [15:0] state_q, state_d, nxt;
  // step every cycle, fold in the mix value, never settle in the all-zero lock-up state
  always_comb begin
    nxt = lfsr_step(state_q) ^ (i_mix ? i_mix_val : 16'h0);
    state_d = (nxt == 16'h0) ? SEED : nxt;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else state_q <= state_d;
  end
  assign o_state = state_q;
endmodule

// File: rtl/card_shoe.sv
// card_shoe: 52-card no-replacement shoe with in-place Fisher-Yates shuffle
module card_shoe import card_shoe_pkg::*; (
  input logic       i_clk,
  input logic       i_reset,
  card_shoe_if.slave bus
);
  shoe_state_e state_q, state_d;
  card_t slot_q [DECK_SIZE];
  card_t slot_d [DECK_SIZE];
  card_t card_q, card_d;
  logic [5:0] ptr_q, ptr_d, idx_q, idx_d, cand;
  logic [15:0] cnt_q, cnt_d, lfsr;
  logic valid_q, valid_d, err_q, err_d, ent_q, ent_d;
  logic accept, deal, bad_draw;

  lfsr16 u_lfsr (
    .clk(i_clk),
    .rst(i_reset),
    .i_mix(bus.i_entropy & ~ent_q),
    .i_mix_val(cnt_q),
    .o_state(lfsr)
  );

  assign cand = lfsr[5:0] & mask_of(idx_q);
  assign accept = state_q == S_SHUFFLE && cand <= idx_q;
  assign deal = state_q == S_READY && bus.i_draw && !bus.i_shuffle;
  assign bad_draw = state_q != S_READY && bus.i_draw && !bus.i_shuffle;

  // state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_FILL;
    else state_q <= state_d;
  end
  // next state: a shuffle request always restarts from a fresh fill
  always_comb begin
    state_d = bus.i_shuffle ? S_FILL :
              state_q == S_FILL ? S_SHUFFLE :
              (accept && idx_q == 6'd1) ? S_READY :
              (deal && ptr_q == 6'(DECK_SIZE - 1)) ? S_EMPTY : state_q;
  end
  // status outputs decoded from state
  always_comb begin
    bus.o_ready = state_q == S_READY;
    bus.o_cardsLeft = (state_q == S_READY || state_q == S_EMPTY) ? 6'(DECK_SIZE) - ptr_q : 6'd0;
  end
  // deck fill, swap step, deal pointer and registered deal/error outputs
  always_comb begin
    slot_d = slot_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    if (state_q == S_FILL) begin
      for (int k = 0; k < DECK_SIZE; k++) slot_d[k] = card_of(k);
      ptr_d = 6'd0;
      idx_d = 6'(DECK_SIZE - 1);
    end else if (accept) begin
      slot_d[idx_q] = slot_q[cand];
      slot_d[cand] = slot_q[idx_q];
      idx_d = idx_q - 6'd1;
    end
    if (deal) ptr_d = ptr_q + 6'd1;
    card_d = deal ? slot_q[ptr_q] : card_q;
    valid_d = deal;
    err_d = bad_draw;
    cnt_d = cnt_q + 16'd1;
    ent_d = bus.i_entropy;
  end
  // control and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr_q <= 6'd0;
      idx_q <= 6'd0;
      card_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= 16'd0;
      ent_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      card_q <= card_d;
      valid_q <= valid_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end
  // deck storage keeps its contents through reset; it is rebuilt in S_FILL
  always_ff @(posedge i_clk) slot_q <= slot_d;

  assign bus.o_card = card_q;
  assign bus.o_cardValid = valid_q;
  assign bus.o_drawError = err_q;
endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: scoreboard bench for the card shoe and its LFSR
module tb_card_shoe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  card_shoe_if bus();
  card_shoe dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  logic lf_rst = 1'b1;
  logic lf_mix = 1'b0;
  logic [15:0] lf_val = 16'h0;
  logic [15:0] lf_state;
  lfsr16 u_lf (.clk(clk), .rst(lf_rst), .i_mix(lf_mix), .i_mix_val(lf_val), .o_state(lf_state));

  typedef struct {bit is_card; logic [5:0] left; int cyc;} exp_t;
  exp_t exp_q[$];
  exp_t e_mon;
  logic [5:0] got[$];
  logic [5:0] golden[$];
  logic [5:0] seq_a[$];
  logic [5:0] last_card;
  int cyc = 0;
  int n = 0;
  int nfail = 0;
  int t0 = 0;
  int diff;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      n++;
      nfail++;
      $display("FAIL missing_output actual=none required=output at cycle %0d", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (bus.o_cardValid || bus.o_drawError) begin
      if (exp_q.size() == 0) begin
        n++;
        nfail++;
        $display("FAIL unexpected_output actual valid=%0b err=%0b required=none", bus.o_cardValid, bus.o_drawError);
      end else begin
        e_mon = exp_q.pop_front();
        chk("out_kind", {30'd0, bus.o_cardValid, bus.o_drawError}, e_mon.is_card ? 32'd2 : 32'd1);
        chk("out_cycle", cyc, e_mon.cyc);
        chk("out_cards_left", {26'd0, bus.o_cardsLeft}, {26'd0, e_mon.left});
        if (bus.o_cardValid) got.push_back(bus.o_card);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check);
    bus.i_shuffle = 1'b0;
    bus.i_draw = 1'b0;
    bus.i_entropy = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    if (check)
      chk("reset_outputs", {17'd0, bus.o_card, bus.o_cardValid, bus.o_ready, bus.o_cardsLeft, bus.o_drawError}, 32'd0);
    exp_q.delete();
    got.delete();
    rst = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_ready(input string nm);
    for (int i = 0; i < 400 && bus.o_ready !== 1'b1; i++) tick();
    chk(nm, {31'd0, bus.o_ready}, 32'd1);
  endtask

  task automatic draw_n(input int k, input bit is_card, input int left0);
    for (int i = 0; i < k; i++) begin
      bus.i_draw = 1'b1;
      exp_q.push_back('{is_card, is_card ? 6'(left0 - 1 - i) : 6'd0, cyc + 1});
      tick();
    end
    bus.i_draw = 1'b0;
  endtask

  task automatic pulse_shuffle;
    bus.i_shuffle = 1'b1;
    tick();
    bus.i_shuffle = 1'b0;
  endtask

  task automatic deal52(input string nm);
    logic [63:0] m;
    int bad;
    got.delete();
    draw_n(52, 1'b1, 52);
    tick();
    m = '0;
    bad = 0;
    foreach (got[i]) begin
      if (got[i][3:0] < 4'd1 || got[i][3:0] > 4'd13) bad++;
      m[got[i]] = 1'b1;
    end
    chk({nm, "_count"}, got.size(), 32'd52);
    chk({nm, "_distinct"}, $countones(m), 32'd52);
    chk({nm, "_ranks"}, bad, 32'd0);
  endtask

  task automatic count_diff(input logic [5:0] a[$], input logic [5:0] b[$]);
    diff = (a.size() == b.size()) ? 0 : 1;
    foreach (a[i]) if (i < b.size() && a[i] !== b[i]) diff++;
  endtask

  task automatic ent_run(input int at);
    do_reset(1'b0);
    while (cyc < t0 + at) tick();
    bus.i_entropy = 1'b1;
    tick();
    bus.i_entropy = 1'b0;
    wait_ready("ent_ready_1");
    pulse_shuffle();
    wait_ready("ent_ready_2");
    deal52("ent_deal");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    do_reset(1'b1);
    wait_ready("ready_after_reset");
    deal52("deal_first");
    golden = got;
    chk("left_after_52", {26'd0, bus.o_cardsLeft}, 32'd0);
    chk("ready_after_52", {31'd0, bus.o_ready}, 32'd0);
    draw_n(1, 1'b0, 0);
    tick();
    chk("left_after_53", {26'd0, bus.o_cardsLeft}, 32'd0);
    chk("ready_after_53", {31'd0, bus.o_ready}, 32'd0);

    do_reset(1'b0);
    draw_n(1, 1'b0, 0);
    while (cyc < t0 + 5) tick();
    draw_n(1, 1'b0, 0);
    wait_ready("ready_after_reset_2");
    deal52("deal_repeat");
    count_diff(got, golden);
    chk("golden_repeat", diff, 32'd0);
    chk("first_card_slot0", {26'd0, got.size() > 0 ? got[0] : 6'd0}, {26'd0, golden[0]});

    do_reset(1'b0);
    while (cyc < t0 + 20) tick();
    pulse_shuffle();
    chk("ready_after_abort", {31'd0, bus.o_ready}, 32'd0);
    wait_ready("ready_after_abort_reshuffle");
    deal52("deal_after_abort");
    last_card = got[got.size() - 1];
    pulse_shuffle();
    wait_ready("ready_before_shuffle_draw");
    bus.i_shuffle = 1'b1;
    bus.i_draw = 1'b1;
    tick();
    bus.i_shuffle = 1'b0;
    bus.i_draw = 1'b0;
    chk("ready_drop_on_shuffle", {31'd0, bus.o_ready}, 32'd0);
    chk("no_card_no_error", {30'd0, bus.o_cardValid, bus.o_drawError}, 32'd0);
    chk("card_held", {26'd0, bus.o_card}, {26'd0, last_card});
    wait_ready("ready_after_shuffle_draw");
    deal52("deal_after_shuffle_draw");

    ent_run(10);
    seq_a = got;
    ent_run(11);
    count_diff(got, seq_a);
    chk("entropy_changes_deal", {31'd0, diff > 0}, 32'd1);

    tick();
    lf_rst = 1'b0;
    chk("lfsr_seed", lf_state, 32'hACE1);
    tick();
    chk("lfsr_step", lf_state, 32'hE270);
    lf_mix = 1'b1;
    lf_val = 16'h7138;
    tick();
    chk("lfsr_zero_guard", lf_state, 32'hACE1);
    lf_val = 16'h0001;
    tick();
    chk("lfsr_mix", lf_state, 32'hE271);
    lf_mix = 1'b0;

    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, nfail);
    $finish;
  end
endmodule
